// File: rtl/timer_periph_pkg.sv
// Shared constants for the timer peripheral: register offsets, TCON bit positions
// and the offset decoder used by both the RTL and CPU-side driver code.
package timer_periph_pkg;

  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
  localparam int TCON_W  = 3;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_SYSTICK
  } reg_sel_e;

  // Takes a word offset (byte offset >> 2) so byte-lane bits never matter.
  function automatic reg_sel_e decode_offset(input logic [29:0] word_off);
    reg_sel_e sel;
    sel = REG_NONE;
    if (word_off == OFF_TH[31:2])           sel = REG_TH;
    else if (word_off == OFF_TL[31:2])      sel = REG_TL;
    else if (word_off == OFF_TCON[31:2])    sel = REG_TCON;
    else if (word_off == OFF_SYSTICK[31:2]) sel = REG_SYSTICK;
    return sel;
  endfunction

endpackage

// File: rtl/timer_core.sv
// Reload timer: TH/TL/TCON registers with overflow reload and sticky interrupt status.
module timer_core
  import timer_periph_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              th_we,
  input  logic              tl_we,
  input  logic              tcon_we,
  input  logic [31:0]       wdata,
  output logic [31:0]       th,
  output logic [31:0]       tl,
  output logic [TCON_W-1:0] tcon,
  output logic              irq
);

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic              tl_at_max;
  logic              overflow;

  assign tl_at_max = (tl_q == 32'hFFFF_FFFF);
  // A CPU write to TL pre-empts both the reload and the status set for that cycle.
  assign overflow  = tcon_q[TCON_EN] && tl_at_max && !tl_we;

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (th_we) th_d = wdata;

    if (tl_we)                tl_d = wdata;
    else if (tcon_q[TCON_EN]) tl_d = tl_at_max ? th_q : tl_q + 32'd1;

    if (tcon_we) tcon_d = wdata[TCON_W-1:0];
    // Hardware set beats a simultaneous software clear of the status bit.
    if (overflow && tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
  assign irq  = tcon_q[TCON_IS] & tcon_q[TCON_IE];

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped timer peripheral: address decode, free-running SYSTICK and the
// zero-latency read mux around timer_core.
module timer_periph
  import timer_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  logic [31:0]       offset;
  reg_sel_e          sel;
  logic              unused_addr_bits;
  logic [31:0]       systick_q, systick_d;
  logic [31:0]       th, tl;
  logic [TCON_W-1:0] tcon;
  logic              th_we, tl_we, tcon_we;

  assign offset           = addr - BASE_ADDR;
  assign sel              = decode_offset(offset[31:2]);
  assign unused_addr_bits = ^offset[1:0];

  assign th_we   = wr && (sel == REG_TH);
  assign tl_we   = wr && (sel == REG_TL);
  assign tcon_we = wr && (sel == REG_TCON);

  assign systick_d = systick_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) systick_q <= '0;
    else       systick_q <= systick_d;
  end

  timer_core u_core (
    .clk     (clk),
    .reset   (reset),
    .th_we   (th_we),
    .tl_we   (tl_we),
    .tcon_we (tcon_we),
    .wdata   (wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irqout)
  );

  // Reads see register state before any same-cycle write lands.
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (sel)
        REG_TH:      rdata = th;
        REG_TL:      rdata = tl;
        REG_TCON:    rdata = {{(32-TCON_W){1'b0}}, tcon};
        REG_SYSTICK: rdata = systick_q;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_periph.sv
// Directed plus randomized bench for timer_periph against a transaction-level model.
module tb_timer_periph;
  import timer_periph_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        irqout;

  always #5 clk = ~clk;

  timer_periph #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irqout (irqout)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the programmer-visible register file.
  logic [31:0] m_th = '0, m_tl = '0, m_tick = '0;
  logic [2:0]  m_tcon = '0;

  logic [31:0] offs [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [31:0] o;
    o = off & 32'hFFFF_FFFC;
    if (o == OFF_TH)           return m_th;
    else if (o == OFF_TL)      return m_tl;
    else if (o == OFF_TCON)    return {29'd0, m_tcon};
    else if (o == OFF_SYSTICK) return m_tick;
    return 32'd0;
  endfunction

  task automatic model_edge(input logic rst, input logic w, input logic [31:0] off,
                            input logic [31:0] d);
    logic [31:0] o, nxt_tl;
    logic [2:0]  nxt_tcon;
    logic        w_tl, hit_max;
    o = off & 32'hFFFF_FFFC;
    if (rst) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_tick = 0;
    end else begin
      w_tl    = w && (o == OFF_TL);
      hit_max = m_tcon[0] && (m_tl == 32'hFFFF_FFFF) && !w_tl;
      if (w_tl)           nxt_tl = d;
      else if (!m_tcon[0]) nxt_tl = m_tl;
      else if (hit_max)    nxt_tl = m_th;
      else                 nxt_tl = m_tl + 1;
      nxt_tcon = (w && o == OFF_TCON) ? d[2:0] : m_tcon;
      if (hit_max && m_tcon[1]) nxt_tcon[2] = 1'b1;
      if (w && o == OFF_TH) m_th = d;
      m_tl   = nxt_tl;
      m_tcon = nxt_tcon;
      m_tick = m_tick + 1;
    end
  endtask

  task automatic cyc(input logic rst, input logic r, input logic w, input logic [31:0] off,
                     input logic [31:0] d, input logic [1:0] lo, output logic [31:0] got);
    reset = rst; rd = r; wr = w; addr = BASE + off + {30'd0, lo}; wdata = d;
    #1;
    got = rdata;
    check("rdata", rdata, r ? model_read(off) : 32'd0);
    @(posedge clk);
    model_edge(rst, w, off, d);
    #1;
    reset = 1'b0; rd = 1'b0; wr = 1'b0;
    check("irqout", {31'd0, irqout}, {31'd0, m_tcon[2] & m_tcon[1]});
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] got;
    cyc(1'b0, 1'b1, 1'b0, off, 32'd0, 2'd0, got);
    check(tag, got, exp);
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] got;
    cyc(1'b0, 1'b0, 1'b1, off, d, 2'd0, got);
  endtask

  task automatic idle();
    logic [31:0] got;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, off, d;
    logic        rst_r, r_r, w_r;
    logic [1:0]  lo;
    offs = '{OFF_TH, OFF_TL, OFF_TCON, OFF_SYSTICK, 32'h0C, 32'h10, 32'h18, 32'h40};
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    @(posedge clk); #1;

    // Reset and empty register window
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, got);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, got);
    rd_exp("rst_systick", OFF_SYSTICK, 32'd0);
    rd_exp("rst_th", OFF_TH, 32'd0);
    rd_exp("rst_tl", OFF_TL, 32'd0);
    rd_exp("rst_tcon", OFF_TCON, 32'd0);
    check("rst_irq", {31'd0, irqout}, 32'd0);

    // Overflow with interrupt enabled
    wr_reg(OFF_TH, 32'hFFFF_FFFD);
    wr_reg(OFF_TL, 32'hFFFF_FFFD);
    wr_reg(OFF_TCON, 32'd3);
    rd_exp("cnt_fd", OFF_TL, 32'hFFFF_FFFD);
    rd_exp("cnt_fe", OFF_TL, 32'hFFFF_FFFE);
    rd_exp("cnt_ff", OFF_TL, 32'hFFFF_FFFF);
    rd_exp("reload_tl", OFF_TL, 32'hFFFF_FFFD);
    rd_exp("ovf_tcon7", OFF_TCON, 32'd7);
    check("ovf_irq1", {31'd0, irqout}, 32'd1);

    // Software clear, then TCON write colliding with overflow
    wr_reg(OFF_TL, 32'h0000_0100);
    wr_reg(OFF_TCON, 32'd3);
    check("clr_irq0", {31'd0, irqout}, 32'd0);
    rd_exp("clr_counting", OFF_TL, 32'h0000_0101);
    wr_reg(OFF_TL, 32'hFFFF_FFFF);
    wr_reg(OFF_TCON, 32'd3);
    rd_exp("set_wins", OFF_TCON, 32'd7);
    check("set_wins_irq", {31'd0, irqout}, 32'd1);

    // Overflow with interrupt disabled
    wr_reg(OFF_TCON, 32'd0);
    wr_reg(OFF_TL, 32'hFFFF_FFFD);
    wr_reg(OFF_TCON, 32'd1);
    rd_exp("noie_fd", OFF_TL, 32'hFFFF_FFFD);
    rd_exp("noie_fe", OFF_TL, 32'hFFFF_FFFE);
    rd_exp("noie_ff", OFF_TL, 32'hFFFF_FFFF);
    rd_exp("noie_reload", OFF_TL, 32'hFFFF_FFFD);
    rd_exp("noie_tcon1", OFF_TCON, 32'd1);
    check("noie_irq0", {31'd0, irqout}, 32'd0);

    // TH write in the overflow cycle reloads the old TH
    wr_reg(OFF_TH, 32'h0000_1234);
    rd_exp("th_old_reload", OFF_TL, 32'hFFFF_FFFD);
    rd_exp("th_fe", OFF_TL, 32'hFFFF_FFFE);
    rd_exp("th_ff", OFF_TL, 32'hFFFF_FFFF);
    rd_exp("th_new_reload", OFF_TL, 32'h0000_1234);

    // TL write in the overflow cycle wins over reload and status set
    wr_reg(OFF_TCON, 32'd3);
    wr_reg(OFF_TL, 32'hFFFF_FFFF);
    wr_reg(OFF_TL, 32'h0000_0010);
    rd_exp("tl_write_wins", OFF_TL, 32'h0000_0010);
    rd_exp("tl_write_noset", OFF_TCON, 32'd3);

    // Reset mid-count, with a competing write
    wr_reg(OFF_TL, 32'h8000_0000);
    cyc(1'b1, 1'b0, 1'b1, OFF_TL, 32'h0000_5555, 2'd0, got);
    rd_exp("mid_rst_systick0", OFF_SYSTICK, 32'd0);
    rd_exp("mid_rst_tl", OFF_TL, 32'd0);
    rd_exp("mid_rst_tcon", OFF_TCON, 32'd0);
    check("mid_rst_irq", {31'd0, irqout}, 32'd0);
    idle();
    idle();
    rd_exp("mid_rst_systick5", OFF_SYSTICK, 32'd5);
    rd_exp("mid_rst_disabled", OFF_TL, 32'd0);

    // Read-during-write and ignored writes
    cyc(1'b0, 1'b1, 1'b1, OFF_TH, 32'hAAAA_5555, 2'd0, got);
    check("rdw_prewrite", got, 32'd0);
    rd_exp("rdw_postwrite", OFF_TH, 32'hAAAA_5555);
    wr_reg(OFF_SYSTICK, 32'h0000_0000);
    wr_reg(32'h0000_000C, 32'hDEAD_BEEF);
    rd_exp("unmapped_read", 32'h0000_000C, 32'd0);
    rd_exp("tcon_hi_ignored", OFF_TCON, 32'd0);
    wr_reg(OFF_TCON, 32'hFFFF_FFF8);
    rd_exp("tcon_hi_masked", OFF_TCON, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_r = ($urandom_range(0, 149) == 0);
      r_r   = $urandom_range(0, 1) == 1;
      w_r   = $urandom_range(0, 2) == 0;
      off   = offs[$urandom_range(0, 7)];
      lo    = 2'($urandom_range(0, 3));
      d     = $urandom;
      if (off == OFF_TL && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 6);
      if (off == OFF_TCON && $urandom_range(0, 1) == 1) d = {29'd0, 3'b011};
      cyc(rst_r, r_r, w_r, off, d, lo, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
